// File: rtl/alu_seq_exec.sv
// Sequential execute unit: one-cycle logic/arithmetic ops and bit-serial shifts
// behind a Start/Ready/Done handshake with the sequencer.
module alu_seq_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [3:0]       ALUControlIn,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Ready,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow,
    output logic             IllegalOp
);
    // state | meaning
    // IDLE  | waiting for Start, Ready=1
    // EXEC  | single-cycle op, result registered on next edge
    // SHIFT | one bit position per edge until count reaches 0

    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_SLT = 4'b1001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] work;
    logic [SW-1:0]    count;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             lt;
    logic [WIDTH-1:0] exec_res;
    logic             exec_ovf;
    logic             exec_ill;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic logic [WIDTH-1:0] shift_one(input logic [3:0] op,
                                                    input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        case (op)
            OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
            OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    assign sum   = a_q + b_q;
    assign diff  = a_q - b_q;
    assign lt    = $signed(a_q) < $signed(b_q);
    assign Ready = (state == IDLE);

    always_comb begin
        exec_res = '0;
        exec_ovf = 1'b0;
        exec_ill = 1'b0;
        case (op_q)
            OP_AND: exec_res = a_q & b_q;
            OP_OR:  exec_res = a_q | b_q;
            OP_ADD: begin
                exec_res = sum;
                exec_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                exec_res = diff;
                exec_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SLT:  exec_res = {{(WIDTH-1){1'b0}}, lt};
            default: exec_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            Done      <= 1'b0;
            Result    <= '0;
            Zero      <= 1'b1;
            Overflow  <= 1'b0;
            IllegalOp <= 1'b0;
            count     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            work      <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        op_q <= ALUControlIn;
                        a_q  <= A;
                        b_q  <= B;
                        if (is_shift(ALUControlIn)) begin
                            work  <= A;
                            count <= B[SW-1:0];
                            state <= SHIFT;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    Result    <= exec_res;
                    Zero      <= (exec_res == '0);
                    Overflow  <= exec_ovf;
                    IllegalOp <= exec_ill;
                    Done      <= 1'b1;
                    state     <= IDLE;
                end
                SHIFT: begin
                    if (count != '0) begin
                        work  <= shift_one(op_q, work);
                        count <= count - SW'(1);
                    end else begin
                        Result    <= work;
                        Zero      <= (work == '0);
                        Overflow  <= 1'b0;
                        IllegalOp <= 1'b0;
                        Done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_exec.sv
// Bench for alu_seq_exec: directed vector table, random ops against a plain
// arithmetic model, and handshake/reset corner sequences.
module tb_alu_seq_exec;
    logic        clk = 1'b0;
    logic        rst;
    logic        Start;
    logic [3:0]  ALUControlIn;
    logic [31:0] A;
    logic [31:0] B;
    logic        Ready;
    logic        Done;
    logic [31:0] Result;
    logic        Zero;
    logic        Overflow;
    logic        IllegalOp;

    int total = 0;
    int bad   = 0;

    alu_seq_exec #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .Start(Start), .ALUControlIn(ALUControlIn),
        .A(A), .B(B), .Ready(Ready), .Done(Done), .Result(Result),
        .Zero(Zero), .Overflow(Overflow), .IllegalOp(IllegalOp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        ill;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Reference behaviour from the op definitions; lat counts edges after the accept edge.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic z, output logic o,
                                  output logic il, output int lat);
        longint sa, sb, s;
        int n;
        sa = $signed(a);
        sb = $signed(b);
        n = int'(b[4:0]);
        r = 32'd0; o = 1'b0; il = 1'b0; lat = 1;
        case (op)
            4'b0000: r = a & b;
            4'b0011: r = a | b;
            4'b0001: begin
                s = sa + sb; r = a + b;
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0010: begin
                s = sa - sb; r = a - b;
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0101: begin r = a << n; lat = 1 + n; end
            4'b0110: begin r = a >> n; lat = 1 + n; end
            4'b1000: begin r = 32'($signed(a) >>> n); lat = 1 + n; end
            4'b1001: r = (sa < sb) ? 32'd1 : 32'd0;
            default: il = 1'b1;
        endcase
        z = (r == 32'd0);
    endfunction

    task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic ez,
                          input logic eo, input logic eil, input int elat, input int glitch);
        int lat;
        bit got;
        @(negedge clk);
        Start = 1'b1; ALUControlIn = op; A = a; B = b;
        @(posedge clk); #1;
        Start = 1'b0;
        chk({nm, ".busy"}, 32'(Ready), 32'd0);
        lat = 0; got = 1'b0;
        while (!got && lat < 40) begin
            if (glitch > 0 && lat == glitch) begin
                Start = 1'b1; ALUControlIn = 4'b0001; A = ~a; B = b ^ 32'h3;
            end
            @(posedge clk); #1;
            lat++;
            Start = 1'b0;
            if (Done) got = 1'b1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL %s.timeout no Done within %0d edges", nm, lat);
        end else begin
            chk({nm, ".lat"}, 32'(lat), 32'(elat));
            chk({nm, ".res"}, Result, er);
            chk({nm, ".zero"}, 32'(Zero), 32'(ez));
            chk({nm, ".ovf"}, 32'(Overflow), 32'(eo));
            chk({nm, ".ill"}, 32'(IllegalOp), 32'(eil));
            chk({nm, ".ready"}, 32'(Ready), 32'd1);
            @(posedge clk); #1;
            chk({nm, ".pulse"}, 32'(Done), 32'd0);
            chk({nm, ".hold"}, Result, er);
        end
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] r, ra, rb;
        logic [3:0]  rop;
        logic z, o, il;
        int lat, dones;

        vecs.push_back('{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b0001, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{4'b0010, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b0010, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{4'b1001, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b1001, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b1000, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0, 1'b0, 5});
        vecs.push_back('{4'b0110, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0, 1'b0, 5});
        vecs.push_back('{4'b0101, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 1'b0, 32});
        vecs.push_back('{4'b0101, 32'h12345678, 32'h00000000, 32'h12345678, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{4'b0101, 32'h00000001, 32'h00000023, 32'h00000008, 1'b0, 1'b0, 1'b0, 4});
        vecs.push_back('{4'b0100, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1});
        vecs.push_back('{4'b1111, 32'h00000003, 32'h00000004, 32'h00000000, 1'b1, 1'b0, 1'b1, 1});

        rst = 1'b1; Start = 1'b0; ALUControlIn = 4'd0; A = 32'd0; B = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", 32'(Ready), 32'd1);
        chk("rst.done", 32'(Done), 32'd0);
        chk("rst.res", Result, 32'd0);
        chk("rst.zero", 32'(Zero), 32'd1);
        chk("rst.ovf", 32'(Overflow), 32'd0);
        chk("rst.ill", 32'(IllegalOp), 32'd0);
        @(negedge clk); rst = 1'b0;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                   vecs[i].zero, vecs[i].ovf, vecs[i].ill, vecs[i].lat, 0);

        // Start pulsed mid-shift must be ignored
        run_op("busy_ign", 4'b0110, 32'h80000000, 32'd10, 32'h00200000, 1'b0, 1'b0, 1'b0, 11, 3);

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = $urandom; rb = $urandom;
            if (i % 4 == 0) rb = rb & 32'h0000000F;
            model(rop, ra, rb, r, z, o, il, lat);
            run_op($sformatf("rnd%0d", i), rop, ra, rb, r, z, o, il, lat, 0);
        end

        // Back-to-back: Start held across the Done cycle
        @(negedge clk);
        Start = 1'b1; ALUControlIn = 4'b0001; A = 32'd3; B = 32'd4;
        @(posedge clk); #1;
        ALUControlIn = 4'b0011; A = 32'h00F0; B = 32'h0F00;
        @(posedge clk); #1;
        chk("b2b.done1", 32'(Done), 32'd1);
        chk("b2b.res1", Result, 32'd7);
        @(posedge clk); #1;
        chk("b2b.gap", 32'(Done), 32'd0);
        chk("b2b.busy", 32'(Ready), 32'd0);
        Start = 1'b0;
        @(posedge clk); #1;
        chk("b2b.done2", 32'(Done), 32'd1);
        chk("b2b.res2", Result, 32'h0FF0);

        // Abort an SLL by 20 with reset; preceding op leaves nonzero result and flags
        run_op("pre_abort", 4'b0001, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0, 1'b1, 1'b0, 1, 0);
        @(negedge clk);
        Start = 1'b1; ALUControlIn = 4'b0101; A = 32'd1; B = 32'd20;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        dones = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (Done) dones++;
        end
        @(negedge clk); rst = 1'b0;
        chk("abort.res", Result, 32'd0);
        chk("abort.zero", 32'(Zero), 32'd1);
        chk("abort.ovf", 32'(Overflow), 32'd0);
        chk("abort.ready", 32'(Ready), 32'd1);
        repeat (25) begin
            @(posedge clk); #1;
            if (Done) dones++;
        end
        chk("abort.nodone", 32'(dones), 32'd0);

        // Reset and Start on the same edge: reset wins
        @(negedge clk);
        rst = 1'b1; Start = 1'b1; ALUControlIn = 4'b0000; A = 32'hFFFF; B = 32'hFFFF;
        @(posedge clk); #1;
        rst = 1'b0; Start = 1'b0;
        chk("rst_start.ready", 32'(Ready), 32'd1);
        dones = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (Done) dones++;
        end
        chk("rst_start.nodone", 32'(dones), 32'd0);
        chk("rst_start.res", Result, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
